// File: rtl/i2c_link_pkg.sv
// i2c_link_pkg: shared types and constants for the I2C link block.
//   mstate_e  : master engine states
//   quarter_e : quarter-phase of an SCL bit cell
//   sstate_e  : slave responder states
//   READ/WRITE: value of the R/W bit that follows the 7-bit address
package i2c_link_pkg;

  typedef enum logic [3:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_ADDR_ACK,
    M_WRITE,
    M_READ,
    M_DATA_ACK,
    M_HOLD,
    M_STOP
  } mstate_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX,
    S_DATA_ACK,
    S_TX,
    S_MACK
  } sstate_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/i2c_link_slave.sv
// i2c_link_slave: addressable I2C slave responder.
//   clk, reset_n  : clock, synchronous active-high reset
//   en            : 0 forces idle and releases SDA
//   sda_i, scl_i  : resolved pin values
//   slave_addr    : own 7-bit address
//   mess          : byte returned on a read
//   sda_low       : 1 = pull SDA low
//   slave_data    : last byte written by the master
module i2c_link_slave
  import i2c_link_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       sda_i,
  input  logic       scl_i,
  input  logic [6:0] slave_addr,
  input  logic [7:0] mess,
  output logic       sda_low,
  output logic [7:0] slave_data
);

  sstate_e    state_q, state_d;
  logic       pin_sda_q, pin_sda_d;
  logic       pin_scl_q, pin_scl_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       rw_q, rw_d;
  logic       drive_q, drive_d;
  logic [7:0] data_q, data_d;

  // Edges compare the live pin with last cycle's copy. The pins are driven
  // by logic in this same clock domain, so one cycle of latency lets the
  // slave change SDA in the same Q0 slot as the master even at DIV=1.
  logic scl_rise, scl_fall, bus_start, bus_stop;
  assign scl_rise  = scl_i & ~pin_scl_q;
  assign scl_fall  = ~scl_i & pin_scl_q;
  assign bus_start = scl_i & pin_scl_q & pin_sda_q & ~sda_i;
  assign bus_stop  = scl_i & pin_scl_q & ~pin_sda_q & sda_i;

  always_comb begin
    state_d   = state_q;
    pin_sda_d = sda_i;
    pin_scl_d = scl_i;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rw_d      = rw_q;
    drive_d   = drive_q;
    data_d    = data_q;
    if (!en || bus_stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else if (bus_start) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      drive_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_i};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (sr_q[7:1] == slave_addr) begin
              drive_d = 1'b1;
              rw_d    = sr_q[0];
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q == WRITE) begin
              drive_d = 1'b0;
              state_d = S_RX;
            end else begin
              sr_d    = mess;
              drive_d = ~mess[7];
              state_d = S_TX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_i};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            data_d  = sr_q;
            drive_d = 1'b1;
            state_d = S_DATA_ACK;
          end
        end
        S_TX: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              drive_d = 1'b0;
              state_d = S_MACK;
            end else begin
              drive_d = ~sr_q[6];
              sr_d    = {sr_q[6:0], 1'b0};
            end
          end
        end
        S_DATA_ACK, S_MACK: begin
          if (scl_fall) begin
            drive_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q   <= S_IDLE;
      pin_sda_q <= 1'b1;
      pin_scl_q <= 1'b1;
      cnt_q     <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      drive_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pin_sda_q <= pin_sda_d;
      pin_scl_q <= pin_scl_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      drive_q   <= drive_d;
      data_q    <= data_d;
    end
  end

  assign sda_low    = drive_q;
  assign slave_data = data_q;

endmodule

// File: rtl/i2c_link.sv
// i2c_link: I2C master engine plus slave responder on one open-drain pair.
//   DIV                 : clk cycles per quarter SCL bit
//   clk, reset_n        : clock, synchronous active-high reset
//   en                  : 0 aborts and releases both lines
//   start, stop, mode   : transaction start edge, stop request, R/W
//   address, regist     : target address and write byte
//   slave_addr, mess    : slave's own address and read-back byte
//   sda, scl            : open-drain bus pins (0 or Z)
//   data_out, slave_data: last byte read by master / written into slave
//   busy, ack_err       : master active / last address NACKed
module i2c_link
  import i2c_link_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [6:0] address,
  input  logic [7:0] regist,
  input  logic [6:0] slave_addr,
  input  logic [7:0] mess,
  inout  wire        sda,
  inout  wire        scl,
  output logic [7:0] data_out,
  output logic [7:0] slave_data,
  output logic       busy,
  output logic       ack_err
);

  localparam int unsigned    QW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0]  QLAST = QW'(DIV - 1);

  mstate_e        state_q, state_d;
  quarter_e       phase_q, phase_d;
  logic [QW-1:0]  qcnt_q, qcnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     regist_q, regist_d;
  logic           mode_q, mode_d;
  logic           stop_req_q, stop_req_d;
  logic           ack_err_q, ack_err_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           start_prev_q, start_prev_d;

  logic tick, cell_end, sample, start_edge, sda_in;
  logic m_sda_low, m_scl_low, s_sda_low;

  assign sda_in     = sda;
  assign tick       = (qcnt_q == QLAST);
  assign cell_end   = tick && (phase_q == Q3);
  assign sample     = tick && (phase_q == Q2);
  assign start_edge = start && !start_prev_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    qcnt_d       = qcnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    regist_d     = regist_q;
    mode_d       = mode_q;
    stop_req_d   = stop_req_q;
    ack_err_d    = ack_err_q;
    data_out_d   = data_out_q;
    start_prev_d = start;

    if (state_q != M_IDLE) begin
      if (tick) begin
        qcnt_d  = '0;
        phase_d = quarter_e'(phase_q + 2'd1);
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
      // A stop request is remembered until the byte is done.
      if (stop) stop_req_d = 1'b1;
    end

    case (state_q)
      M_IDLE: begin
        if (en && start_edge) begin
          state_d    = M_START;
          shift_d    = {address, mode};
          regist_d   = regist;
          mode_d     = mode;
          stop_req_d = stop;
          bit_d      = '0;
        end
      end
      M_START: if (cell_end) state_d = M_ADDR;
      M_ADDR, M_WRITE: begin
        if (cell_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == M_ADDR) ? M_ADDR_ACK : M_DATA_ACK;
        end
      end
      M_ADDR_ACK: begin
        if (sample) ack_err_d = sda_in;
        if (cell_end) begin
          if (ack_err_q) begin
            state_d = M_STOP;
          end else begin
            bit_d   = '0;
            shift_d = regist_q;
            state_d = (mode_q == READ) ? M_READ : M_WRITE;
          end
        end
      end
      M_READ: begin
        if (sample) begin
          shift_d = {shift_q[6:0], sda_in};
          if (bit_q == 3'd7) data_out_d = {shift_q[6:0], sda_in};
        end
        if (cell_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = M_DATA_ACK;
        end
      end
      M_DATA_ACK: if (cell_end) state_d = M_HOLD;
      M_HOLD: if (cell_end && stop_req_q) state_d = M_STOP;
      M_STOP: begin
        if (cell_end) begin
          state_d    = M_IDLE;
          stop_req_d = 1'b0;
        end
      end
      default: state_d = M_IDLE;
    endcase

    if (!en) begin
      state_d    = M_IDLE;
      phase_d    = Q0;
      qcnt_d     = '0;
      stop_req_d = 1'b0;
    end
  end

  // Line drive per state and quarter: SCL low in Q0/Q3 of data cells,
  // SDA only changes at Q0 except for START/STOP conditions.
  always_comb begin
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    case (state_q)
      M_START: begin
        m_scl_low = (phase_q == Q3);
        m_sda_low = (phase_q == Q2) || (phase_q == Q3);
      end
      M_ADDR, M_WRITE: begin
        m_scl_low = (phase_q == Q0) || (phase_q == Q3);
        m_sda_low = ~shift_q[7];
      end
      M_ADDR_ACK, M_READ, M_DATA_ACK: begin
        m_scl_low = (phase_q == Q0) || (phase_q == Q3);
      end
      M_HOLD: begin
        m_scl_low = 1'b1;
        m_sda_low = 1'b1;
      end
      M_STOP: begin
        m_scl_low = (phase_q == Q0);
        m_sda_low = (phase_q != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset_n) begin
      state_q      <= M_IDLE;
      phase_q      <= Q0;
      qcnt_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      regist_q     <= '0;
      mode_q       <= 1'b0;
      stop_req_q   <= 1'b0;
      ack_err_q    <= 1'b0;
      data_out_q   <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      qcnt_q       <= qcnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      regist_q     <= regist_d;
      mode_q       <= mode_d;
      stop_req_q   <= stop_req_d;
      ack_err_q    <= ack_err_d;
      data_out_q   <= data_out_d;
      start_prev_q <= start_prev_d;
    end
  end

  i2c_link_slave u_slave (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .sda_i      (sda),
    .scl_i      (scl),
    .slave_addr (slave_addr),
    .mess       (mess),
    .sda_low    (s_sda_low),
    .slave_data (slave_data)
  );

  assign sda = (m_sda_low || s_sda_low) ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  // busy drops during the final cycle of the STOP cell.
  assign busy     = (state_q != M_IDLE) && !((state_q == M_STOP) && cell_end);
  assign ack_err  = ack_err_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_i2c_link.sv
// tb_i2c_link: directed self-checking bench for i2c_link at DIV=1.
// Cycle index i counts negedges after the start edge; i=0 is START Q0.
// Cells: START 0-3, ADDR 4-35, ADDR_ACK 36-39, data 40-71,
// DATA_ACK 72-75, HOLD 76-79, STOP 80-83. Bits sampled at Q2 (base+2).
module tb_i2c_link;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] address = 7'h00;
  logic [7:0] regist = 8'h00;
  logic [6:0] slave_addr = 7'h70;
  logic [7:0] mess = 8'h00;
  wire        sda, scl;
  logic [7:0] data_out, slave_data;
  logic       busy, ack_err;

  pullup (sda);
  pullup (scl);

  i2c_link #(.DIV(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .address    (address),
    .regist     (regist),
    .slave_addr (slave_addr),
    .mess       (mess),
    .sda        (sda),
    .scl        (scl),
    .data_out   (data_out),
    .slave_data (slave_data),
    .busy       (busy),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic sda_tr  [0:511];
  logic scl_tr  [0:511];
  logic busy_tr [0:511];
  logic pre_busy;
  int   blen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rebuild a byte from the trace: eight bits, one cell (4 cycles) apart.
  function automatic logic [7:0] bus_byte(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = sda_tr[base + 4*k];
    return b;
  endfunction

  // Launch one transaction and trace the bus. stop pulses for one cycle at
  // index stop_at (negative: together with the start edge). len returns the
  // first index with busy low, or -1 if busy never fell within max_cyc.
  task automatic run_txn(input logic m, input logic [6:0] a, input logic [6:0] sa,
                         input logic [7:0] r, input logic [7:0] ms,
                         input int stop_at, input int max_cyc, output int len);
    @(negedge clk);
    mode = m; address = a; slave_addr = sa; regist = r; mess = ms;
    stop = (stop_at < 0);
    start = 1'b1;
    pre_busy = busy;
    len = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop = (i == stop_at);
      sda_tr[i] = sda;
      scl_tr[i] = scl;
      busy_tr[i] = busy;
      if (!busy && len < 0) len = i;
      if (len >= 0 && i >= len + 1) break;
    end
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_slave_data", slave_data, 8'h00);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_lines", {scl, sda}, 2'b11);

    // Write 0x55 to matching address 0x70, stop requested right away.
    run_txn(1'b0, 7'h70, 7'h70, 8'h55, 8'h00, 0, 200, blen);
    check("wr_busy_pre", pre_busy, 1'b0);
    check("wr_busy_rise", busy_tr[0], 1'b1);
    check("wr_addr_byte", bus_byte(6), 8'hE0);
    check("wr_addr_ack", sda_tr[38], 1'b0);
    check("wr_data_byte", bus_byte(42), 8'h55);
    check("wr_data_ack", sda_tr[74], 1'b0);
    check("wr_ack_cell_scl", scl_tr[74], 1'b1);
    check("wr_hold", {scl_tr[77], sda_tr[77]}, 2'b00);
    check("wr_stop_mid", {scl_tr[81], sda_tr[81]}, 2'b10);
    check("wr_stop_end", {scl_tr[83], sda_tr[83]}, 2'b11);
    check("wr_busy_len", (blen >= 80 && blen <= 84), 1'b1);
    check("wr_slave_data", slave_data, 8'h55);
    check("wr_ack_err", ack_err, 1'b0);
    check("wr_lines_idle", {scl, sda}, 2'b11);

    // Read 0xAA back from the slave.
    run_txn(1'b1, 7'h70, 7'h70, 8'h00, 8'hAA, 0, 200, blen);
    check("rd_addr_byte", bus_byte(6), 8'hE1);
    check("rd_addr_ack", sda_tr[38], 1'b0);
    check("rd_bus_byte", bus_byte(42), 8'hAA);
    check("rd_data_out", data_out, 8'hAA);
    check("rd_nack", {scl_tr[74], sda_tr[74]}, 2'b11);
    check("rd_stop_mid", {scl_tr[81], sda_tr[81]}, 2'b10);
    check("rd_stop_end", {scl_tr[83], sda_tr[83]}, 2'b11);
    check("rd_busy_len", (blen >= 80 && blen <= 84), 1'b1);
    check("rd_slave_data", slave_data, 8'h55);

    // Address mismatch: NACK, STOP straight after ADDR_ACK.
    run_txn(1'b0, 7'h70, 7'h71, 8'h99, 8'h00, 0, 200, blen);
    check("nk_ack_bit", sda_tr[38], 1'b1);
    check("nk_ack_err", ack_err, 1'b1);
    check("nk_stop_mid", {scl_tr[41], sda_tr[41]}, 2'b10);
    check("nk_stop_end", {scl_tr[43], sda_tr[43]}, 2'b11);
    check("nk_busy_len", (blen >= 40 && blen <= 44), 1'b1);
    check("nk_slave_data", slave_data, 8'h55);
    check("nk_data_out", data_out, 8'hAA);

    // Stop pulsed during the address phase: full byte, then STOP.
    run_txn(1'b0, 7'h70, 7'h70, 8'hA5, 8'h00, 5, 200, blen);
    check("es_data_byte", bus_byte(42), 8'hA5);
    check("es_slave_data", slave_data, 8'hA5);
    check("es_ack_err", ack_err, 1'b0);
    check("es_hold", {scl_tr[77], sda_tr[77]}, 2'b00);
    check("es_stop_mid", {scl_tr[81], sda_tr[81]}, 2'b10);
    check("es_busy_len", (blen >= 80 && blen <= 84), 1'b1);

    // Stop together with the start edge: start wins, stop honoured in HOLD.
    run_txn(1'b0, 7'h70, 7'h70, 8'h0F, 8'h00, -1, 200, blen);
    check("ss_slave_data", slave_data, 8'h0F);
    check("ss_busy_len", (blen >= 80 && blen <= 84), 1'b1);

    // Reset for one cycle during data bit 3 (cells 52-55).
    run_txn(1'b0, 7'h70, 7'h70, 8'hF0, 8'h00, 999, 54, blen);
    check("mr_busy_before", busy, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("mr_busy", busy, 1'b0);
    check("mr_data_out", data_out, 8'h00);
    check("mr_slave_data", slave_data, 8'h00);
    check("mr_ack_err", ack_err, 1'b0);
    check("mr_lines", {scl, sda}, 2'b11);
    reset_n = 1'b0;

    // en dropped while holding the bus, then a fresh write.
    run_txn(1'b0, 7'h70, 7'h70, 8'h3C, 8'h00, 999, 79, blen);
    check("en_hold_busy", busy_tr[78], 1'b1);
    check("en_hold_lines", {scl_tr[78], sda_tr[78]}, 2'b00);
    check("en_byte_stored", slave_data, 8'h3C);
    en = 1'b0;
    @(negedge clk);
    check("en_off_busy", busy, 1'b0);
    check("en_off_lines", {scl, sda}, 2'b11);
    en = 1'b1;
    run_txn(1'b0, 7'h70, 7'h70, 8'hC3, 8'h00, 0, 200, blen);
    check("en_re_slave_data", slave_data, 8'hC3);
    check("en_re_busy_len", (blen >= 80 && blen <= 84), 1'b1);
    check("en_re_lines", {scl, sda}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
